// File: rtl/axi4_slave_sink_if.sv
// AXI4-MM bus bundle for axi4_slave_sink: the five AXI channels with
// master (driver of AW/W/AR, consumer of B/R) and slave modports.
//
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where VALID and READY are both 1. Once VALID is raised, the source holds
// VALID and its payload stable until that transfer. READY may change freely.
interface axi4_slave_sink_if #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int IW = 4
);
  // write address channel
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [7:0]      S_AXI_AWLEN;
  logic [2:0]      S_AXI_AWSIZE;
  logic [IW-1:0]   S_AXI_AWID;
  logic [1:0]      S_AXI_AWBURST;
  logic            S_AXI_AWLOCK;
  logic [3:0]      S_AXI_AWCACHE;
  logic [3:0]      S_AXI_AWQOS;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  // write data channel
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WLAST;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  // write response channel
  logic [IW-1:0]   S_AXI_BID;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  // read address channel
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [7:0]      S_AXI_ARLEN;
  logic [2:0]      S_AXI_ARSIZE;
  logic [IW-1:0]   S_AXI_ARID;
  logic [1:0]      S_AXI_ARBURST;
  logic            S_AXI_ARLOCK;
  logic [3:0]      S_AXI_ARCACHE;
  logic [3:0]      S_AXI_ARQOS;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  // read data channel
  logic [DW-1:0]   S_AXI_RDATA;
  logic [IW-1:0]   S_AXI_RID;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RLAST;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWID, S_AXI_AWBURST,
           S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWVALID,
           S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
           S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARID, S_AXI_ARBURST,
           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
           S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWID, S_AXI_AWBURST,
           S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWVALID,
           S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
           S_AXI_BREADY,
           S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARID, S_AXI_ARBURST,
           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
           S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_slave_sink.sv
// axi4_slave_sink: AXI4-MM termination. Write bursts are swallowed and
// answered with a B response (SLVERR if WLAST was misplaced); read bursts
// return ARLEN+1 beats of generated data. Completed bursts are counted.
// Optional feature macro AXI_SINK_PATTERN_EN: when defined, each R beat
// carries its zero-extended beat address replicated across RDATA; when
// undefined, RDATA is constant 0 and no address tracking exists.
// All outputs come straight from flops whose next value is decoded from the
// next FSM state, so they change only on clk edges (or on async reset).
module axi4_slave_sink #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int IW = 4
) (
  input  logic        clk,
  input  logic        resetn,
  axi4_slave_sink_if.slave s_axi,
  output logic [31:0] wr_burst_count,
  output logic [31:0] rd_burst_count
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // ---------------- write side ----------------
  w_state_e      w_state_q, w_state_d;
  logic [IW-1:0] awid_q, awid_d;
  logic [7:0]    awlen_q, awlen_d;
  logic [8:0]    w_beats_q, w_beats_d;
  logic          w_err_q, w_err_d;
  logic [31:0]   wr_cnt_q, wr_cnt_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [IW-1:0] bid_q, bid_d;
  logic [1:0]    bresp_q, bresp_d;

  logic          aw_hs, w_hs, b_hs, w_final;
  logic [8:0]    w_beat_next;

  assign aw_hs       = s_axi.S_AXI_AWVALID && awready_q;
  assign w_hs        = s_axi.S_AXI_WVALID && wready_q;
  assign b_hs        = bvalid_q && s_axi.S_AXI_BREADY;
  assign w_beat_next = w_beats_q + 9'd1;
  // Burst ends on beat count alone; WLAST only feeds the error flag.
  assign w_final     = (w_beat_next == ({1'b0, awlen_q} + 9'd1));

  // Write FSM state and burst bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      awlen_q   <= '0;
      w_beats_q <= '0;
      w_err_q   <= 1'b0;
      wr_cnt_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      awlen_q   <= awlen_d;
      w_beats_q <= w_beats_d;
      w_err_q   <= w_err_d;
      wr_cnt_q  <= wr_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM next state: AW latch, beat counting, WLAST check, B completion
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    awlen_d   = awlen_q;
    w_beats_d = w_beats_q;
    w_err_d   = w_err_q;
    wr_cnt_d  = wr_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          awid_d    = s_axi.S_AXI_AWID;
          awlen_d   = s_axi.S_AXI_AWLEN;
          w_beats_d = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_beats_d = w_beat_next;
          if (s_axi.S_AXI_WLAST != w_final) w_err_d = 1'b1;
          if (w_final) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_cnt_d  = wr_cnt_q + 32'd1;
          w_err_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from the next state, registered above
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bid_d     = bvalid_d ? awid_d : '0;
    bresp_d   = (bvalid_d && w_err_d) ? 2'b10 : 2'b00;
  end

  // ---------------- read side ----------------
  r_state_e      r_state_q, r_state_d;
  logic [IW-1:0] arid_q, arid_d;
  logic [7:0]    arlen_q, arlen_d;
  logic [7:0]    r_beats_q, r_beats_d;
  logic [31:0]   rd_cnt_q, rd_cnt_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [IW-1:0] rid_q, rid_d;
  logic          rlast_q, rlast_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          ar_hs, r_hs;

  assign ar_hs = s_axi.S_AXI_ARVALID && arready_q;
  assign r_hs  = rvalid_q && s_axi.S_AXI_RREADY;

`ifdef AXI_SINK_PATTERN_EN
  logic [AW-1:0] r_addr_q, r_addr_d;
  logic [2:0]    r_size_q, r_size_d;
  logic [1:0]    r_burst_q, r_burst_d;

  // Beat address tracking for the generated read pattern
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
    end else begin
      r_addr_q  <= r_addr_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
    end
  end

  // Next beat address: INCR and WRAP step by the beat size, FIXED/reserved hold
  always_comb begin
    r_addr_d  = r_addr_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    if (r_state_q == R_IDLE && ar_hs) begin
      r_addr_d  = s_axi.S_AXI_ARADDR;
      r_size_d  = s_axi.S_AXI_ARSIZE;
      r_burst_d = s_axi.S_AXI_ARBURST;
    end else if (r_state_q == R_DATA && r_hs) begin
      if (r_burst_q == 2'b01 || r_burst_q == 2'b10)
        r_addr_d = r_addr_q + (AW'(1) << r_size_q);
    end
  end
`endif

  // Read FSM state and burst bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      arlen_q   <= '0;
      r_beats_q <= '0;
      rd_cnt_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      r_beats_q <= r_beats_d;
      rd_cnt_q  <= rd_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read FSM next state: AR latch, beat advance, completion on the RLAST beat
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;
    r_beats_d = r_beats_q;
    rd_cnt_d  = rd_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          arid_d    = s_axi.S_AXI_ARID;
          arlen_d   = s_axi.S_AXI_ARLEN;
          r_beats_d = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          r_beats_d = r_beats_q + 8'd1;
          if (r_beats_q == arlen_q) begin
            rd_cnt_d  = rd_cnt_q + 32'd1;
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from the next state, registered above
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rid_d     = rvalid_d ? arid_d : '0;
    rlast_d   = rvalid_d && (r_beats_d == arlen_d);
    rdata_d   = '0;
`ifdef AXI_SINK_PATTERN_EN
    if (rvalid_d) rdata_d = {(DW/64){64'(r_addr_d)}};
`endif
  end

  // Inputs that the sink deliberately ignores
  logic unused_inputs;
`ifdef AXI_SINK_PATTERN_EN
  assign unused_inputs = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST,
                           s_axi.S_AXI_AWLOCK, s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWQOS,
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB,
                           s_axi.S_AXI_ARLOCK, s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARQOS,
                           s_axi.S_AXI_ARPROT};
`else
  assign unused_inputs = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST,
                           s_axi.S_AXI_AWLOCK, s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWQOS,
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB,
                           s_axi.S_AXI_ARLOCK, s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARQOS,
                           s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARADDR, s_axi.S_AXI_ARSIZE,
                           s_axi.S_AXI_ARBURST};
`endif

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BID     = bid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RID     = rid_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign wr_burst_count      = wr_cnt_q;
  assign rd_burst_count      = rd_cnt_q;

endmodule

// File: tb/tb_axi4_slave_sink.sv
// Directed bench for axi4_slave_sink. Inputs are driven and outputs sampled
// on the falling clk edge; the DUT acts on the rising edge in between.
module tb_axi4_slave_sink;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] wr_burst_count, rd_burst_count;

  always #5 clk = ~clk;

  axi4_slave_sink_if #(.DW(DW), .AW(AW), .IW(IW)) axi ();

  axi4_slave_sink #(.DW(DW), .AW(AW), .IW(IW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_axi          (axi),
    .wr_burst_count (wr_burst_count),
    .rd_burst_count (rd_burst_count)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0]   exp_q[$];     // expected RDATA per read beat
  logic [IW+1:0]   exp_b_q[$];   // expected {BID, BRESP} per write burst
  int              n_vec = 0;
  int              n_err = 0;
  logic [31:0]     exp_wr = 0;
  logic [31:0]     exp_rd = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
`ifdef AXI_SINK_PATTERN_EN
    return {(DW/64){64'(a)}};
`else
    return (a == a) ? '0 : '1;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [IW-1:0] id, input logic [7:0] len,
                          input int wl, input int bdelay);
    int cyc = 0;
    logic [IW+1:0] e;
    exp_b_q.push_back({id, (wl == int'(len) + 1) ? 2'b00 : 2'b10});
    axi.S_AXI_AWID = id;
    axi.S_AXI_AWLEN = len;
    axi.S_AXI_AWADDR = AW'($urandom);
    axi.S_AXI_AWVALID = 1'b1;
    while (axi.S_AXI_AWREADY !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("aw_wait", DW'(cyc < 50), DW'(1));
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    chk("awready_after_aw", DW'(axi.S_AXI_AWREADY), DW'(0));
    chk("wready_after_aw", DW'(axi.S_AXI_WREADY), DW'(1));
    for (int b = 1; b <= int'(len) + 1; b++) begin
      axi.S_AXI_WVALID = 1'b1;
      axi.S_AXI_WLAST = (b == wl);
      axi.S_AXI_WDATA = {16{$urandom}};
      axi.S_AXI_WSTRB = {2{$urandom}};
      chk("wready_beat", DW'(axi.S_AXI_WREADY), DW'(1));
      @(negedge clk);
    end
    axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_WLAST = 1'b0;
    chk("wready_after_last", DW'(axi.S_AXI_WREADY), DW'(0));
    chk("bvalid_after_last", DW'(axi.S_AXI_BVALID), DW'(1));
    e = exp_b_q.pop_front();
    chk("bid", DW'(axi.S_AXI_BID), DW'(e[IW+1:2]));
    chk("bresp", DW'(axi.S_AXI_BRESP), DW'(e[1:0]));
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      chk("bvalid_hold", DW'(axi.S_AXI_BVALID), DW'(1));
      chk("bid_hold", DW'(axi.S_AXI_BID), DW'(e[IW+1:2]));
    end
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    exp_wr = exp_wr + 32'd1;
    chk("bvalid_after_b", DW'(axi.S_AXI_BVALID), DW'(0));
    chk("awready_after_b", DW'(axi.S_AXI_AWREADY), DW'(1));
    chk("wr_burst_count", DW'(wr_burst_count), DW'(exp_wr));
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [7:0] len,
                         input logic [AW-1:0] addr, input logic [2:0] size,
                         input logic [1:0] burst, input bit toggle);
    logic [AW-1:0] a = addr;
    int cyc = 0;
    int i = 0;
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back(beat_data(a));
      if (burst == 2'b01 || burst == 2'b10) a = a + (64'd1 << size);
    end
    axi.S_AXI_ARID = id;
    axi.S_AXI_ARLEN = len;
    axi.S_AXI_ARADDR = addr;
    axi.S_AXI_ARSIZE = size;
    axi.S_AXI_ARBURST = burst;
    axi.S_AXI_ARVALID = 1'b1;
    while (axi.S_AXI_ARREADY !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ar_wait", DW'(cyc < 50), DW'(1));
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    chk("arready_after_ar", DW'(axi.S_AXI_ARREADY), DW'(0));
    cyc = 0;
    while (i <= int'(len) && cyc < 600) begin
      axi.S_AXI_RREADY = toggle ? ((cyc % 2) == 0) : 1'b1;
      chk("rvalid", DW'(axi.S_AXI_RVALID), DW'(1));
      chk("rdata", axi.S_AXI_RDATA, exp_q[0]);
      chk("rid", DW'(axi.S_AXI_RID), DW'(id));
      chk("rresp", DW'(axi.S_AXI_RRESP), DW'(0));
      chk("rlast", DW'(axi.S_AXI_RLAST), DW'(i == int'(len)));
      if (axi.S_AXI_RREADY) begin
        void'(exp_q.pop_front());
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    axi.S_AXI_RREADY = 1'b0;
    exp_rd = exp_rd + 32'd1;
    chk("r_beats_done", DW'(i), DW'(int'(len) + 1));
    chk("rvalid_after_last", DW'(axi.S_AXI_RVALID), DW'(0));
    chk("arready_after_last", DW'(axi.S_AXI_ARREADY), DW'(1));
    chk("rd_burst_count", DW'(rd_burst_count), DW'(exp_rd));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    axi.S_AXI_AWADDR = '0;  axi.S_AXI_AWLEN = '0;  axi.S_AXI_AWSIZE = 3'd6;
    axi.S_AXI_AWID = '0;    axi.S_AXI_AWBURST = 2'b01; axi.S_AXI_AWLOCK = 1'b0;
    axi.S_AXI_AWCACHE = '0; axi.S_AXI_AWQOS = '0;  axi.S_AXI_AWPROT = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;   axi.S_AXI_WSTRB = '0;  axi.S_AXI_WLAST = 1'b0;
    axi.S_AXI_WVALID = 1'b0; axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0;  axi.S_AXI_ARLEN = '0;  axi.S_AXI_ARSIZE = '0;
    axi.S_AXI_ARID = '0;    axi.S_AXI_ARBURST = '0; axi.S_AXI_ARLOCK = 1'b0;
    axi.S_AXI_ARCACHE = '0; axi.S_AXI_ARQOS = '0;  axi.S_AXI_ARPROT = '0;
    axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;

    // reset held for 5 cycles: every output is 0
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_awready", DW'(axi.S_AXI_AWREADY), DW'(0));
    chk("rst_arready", DW'(axi.S_AXI_ARREADY), DW'(0));
    chk("rst_wready", DW'(axi.S_AXI_WREADY), DW'(0));
    chk("rst_bvalid", DW'(axi.S_AXI_BVALID), DW'(0));
    chk("rst_bid_bresp", DW'({axi.S_AXI_BID, axi.S_AXI_BRESP}), DW'(0));
    chk("rst_rvalid", DW'(axi.S_AXI_RVALID), DW'(0));
    chk("rst_rid_rresp_rlast", DW'({axi.S_AXI_RID, axi.S_AXI_RRESP, axi.S_AXI_RLAST}), DW'(0));
    chk("rst_rdata", axi.S_AXI_RDATA, '0);
    chk("rst_counts", DW'({wr_burst_count, rd_burst_count}), DW'(0));

    // release: READYs rise on the first edge after release
    resetn = 1'b1;
    #1;
    chk("rel_awready_before_edge", DW'(axi.S_AXI_AWREADY), DW'(0));
    @(negedge clk);
    chk("rel_awready", DW'(axi.S_AXI_AWREADY), DW'(1));
    chk("rel_arready", DW'(axi.S_AXI_ARREADY), DW'(1));
    chk("rel_counts", DW'({wr_burst_count, rd_burst_count}), DW'(0));

    // W beat offered before any AW is not accepted
    axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_WDATA = {16{$urandom}};
    @(negedge clk);
    chk("wready_idle", DW'(axi.S_AXI_WREADY), DW'(0));
    axi.S_AXI_WVALID = 1'b0;

    // clean write, misplaced WLAST write, then clean write with B stall
    do_write(4'h5, 8'd3, 4, 0);
    do_write(4'h6, 8'd3, 2, 0);
    do_write(4'h7, 8'd3, 4, 2);
    do_write(4'($urandom_range(0, 15)), 8'd0, 0, 1);
    do_write(4'h8, 8'd1, 2, 0);

    // INCR read with RREADY toggling, FIXED, WRAP (as INCR), reserved
    do_read(4'h3, 8'd7, 64'h1000, 3'd6, 2'b01, 1'b1);
    do_read(4'h9, 8'd2, 64'h2000, 3'd3, 2'b00, 1'b0);
    do_read(4'hA, 8'd3, 64'h30F0, 3'd4, 2'b10, 1'b0);
    do_read(4'h1, 8'd1, 64'h5008, 3'd2, 2'b11, 1'b1);
    do_read(4'hE, 8'd0, 64'hFFFF_FFFF_FFFF_FFC0, 3'd6, 2'b01, 1'b0);

    // AW and AR accepted in the same cycle, B held off for 10 cycles
    fork
      do_write(4'hB, 8'd1, 2, 10);
      do_read(4'hC, 8'd5, 64'h4000, 3'd6, 2'b01, 1'b0);
    join

    // reset during beat 3 of a 16-beat read
    axi.S_AXI_ARID = 4'h2;
    axi.S_AXI_ARLEN = 8'd15;
    axi.S_AXI_ARADDR = 64'h8000;
    axi.S_AXI_ARSIZE = 3'd6;
    axi.S_AXI_ARBURST = 2'b01;
    axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;
    repeat (2) @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    chk("mid_rvalid_before_rst", DW'(axi.S_AXI_RVALID), DW'(1));
    chk("mid_rlast_before_rst", DW'(axi.S_AXI_RLAST), DW'(0));
    resetn = 1'b0;
    #1;
    chk("mid_rvalid_async", DW'(axi.S_AXI_RVALID), DW'(0));
    chk("mid_counts_cleared", DW'({wr_burst_count, rd_burst_count}), DW'(0));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp_wr = 32'd0;
    exp_rd = 32'd0;
    chk("mid_arready_after", DW'(axi.S_AXI_ARREADY), DW'(1));
    chk("mid_rvalid_after", DW'(axi.S_AXI_RVALID), DW'(0));
    chk("mid_rd_count_after", DW'(rd_burst_count), DW'(0));
    do_read(4'hD, 8'd1, 64'h500, 3'd6, 2'b01, 1'b0);
    do_write(4'h4, 8'd2, 3, 0);

    chk("exp_q_drained", DW'(exp_q.size() + exp_b_q.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
